// File: rtl/credit_duplex_xbar.sv
// NumIn x NumOut full-duplex crossbar with round-robin arbitration on both paths, per-initiator
// outstanding-credit limit, optional response register stage and a sticky protocol-error flag.
module credit_duplex_xbar #(
    parameter int NumIn          = 4,
    parameter int NumOut         = 4,
    parameter int ReqDataWidth   = 32,
    parameter int RespDataWidth  = 32,
    parameter int MaxOutstanding = 8,
    parameter int RespReg        = 0,
    localparam int NumInLog      = (NumIn == 1) ? 1 : $clog2(NumIn),
    localparam int NumOutLog     = (NumOut == 1) ? 1 : $clog2(NumOut),
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumIn-1:0]                req_valid_i,
    output logic [NumIn-1:0]                req_ready_o,
    input  logic [NumIn*NumOutLog-1:0]      req_tgt_addr_i,
    input  logic [NumIn*ReqDataWidth-1:0]   req_wdata_i,
    output logic [NumIn-1:0]                resp_valid_o,
    input  logic [NumIn-1:0]                resp_ready_i,
    output logic [NumIn*RespDataWidth-1:0]  resp_rdata_o,
    output logic [NumOut-1:0]               req_valid_o,
    input  logic [NumOut-1:0]               req_ready_i,
    output logic [NumOut*NumInLog-1:0]      req_ini_addr_o,
    output logic [NumOut*ReqDataWidth-1:0]  req_wdata_o,
    input  logic [NumOut-1:0]               resp_valid_i,
    output logic [NumOut-1:0]               resp_ready_o,
    input  logic [NumOut*NumInLog-1:0]      resp_ini_addr_i,
    input  logic [NumOut*RespDataWidth-1:0] resp_rdata_i,
    output logic [NumIn*CntW-1:0]           outstanding_o,
    output logic                            idle_o,
    output logic                            err_o
);

    logic [CntW-1:0]          cnt_q [NumIn];
    logic [CntW-1:0]          cnt_d [NumIn];
    logic [NumOut-1:0]        req_lock_q, req_lock_d;
    logic [NumInLog-1:0]      req_lidx_q [NumOut];
    logic [NumInLog-1:0]      req_lidx_d [NumOut];
    logic [NumInLog-1:0]      req_ptr_q [NumOut];
    logic [NumInLog-1:0]      req_ptr_d [NumOut];
    logic [NumIn-1:0]         rsp_lock_q, rsp_lock_d;
    logic [NumOutLog-1:0]     rsp_lidx_q [NumIn];
    logic [NumOutLog-1:0]     rsp_lidx_d [NumIn];
    logic [NumOutLog-1:0]     rsp_ptr_q [NumIn];
    logic [NumOutLog-1:0]     rsp_ptr_d [NumIn];
    logic [NumIn-1:0]         vld_q, vld_d;
    logic [RespDataWidth-1:0] rdata_q [NumIn];
    logic [RespDataWidth-1:0] rdata_d [NumIn];
    logic                     err_q, err_d;

    logic [NumIn-1:0]         req_elig [NumOut];
    logic [NumInLog-1:0]      req_gnt [NumOut];
    logic [NumOut-1:0]        req_found;
    logic [NumOut-1:0]        rsp_cand [NumIn];
    logic [NumOutLog-1:0]     rsp_gnt [NumIn];
    logic [NumIn-1:0]         rsp_found;
    logic [NumIn-1:0]         stage_ready;
    logic [NumIn-1:0]         rsp_tgt_hs;
    logic [RespDataWidth-1:0] rsp_sel [NumIn];
    int                       req_idx;
    int                       rsp_idx;

    // Request path: a held grant wins over round-robin until its handshake completes.
    always_comb begin
        req_valid_o    = '0;
        req_ready_o    = '0;
        req_ini_addr_o = '0;
        req_wdata_o    = '0;
        req_found      = '0;
        req_elig       = '{default: '0};
        req_gnt        = '{default: '0};
        req_idx        = 0;
        for (int t = 0; t < NumOut; t++) begin
            for (int i = 0; i < NumIn; i++) begin
                req_elig[t][i] = req_valid_i[i]
                    && (req_tgt_addr_i[i*NumOutLog +: NumOutLog] == NumOutLog'(t))
                    && (cnt_q[i] < CntW'(MaxOutstanding));
            end
            if (req_lock_q[t]) begin
                req_gnt[t]   = req_lidx_q[t];
                req_found[t] = req_elig[t][req_lidx_q[t]];
            end else begin
                for (int k = 0; k < NumIn; k++) begin
                    req_idx = int'(req_ptr_q[t]) + k;
                    if (req_idx >= NumIn) req_idx = req_idx - NumIn;
                    if (!req_found[t] && req_elig[t][req_idx]) begin
                        req_found[t] = 1'b1;
                        req_gnt[t]   = NumInLog'(req_idx);
                    end
                end
            end
            req_valid_o[t] = req_found[t] && !rst_i;
            req_ini_addr_o[t*NumInLog +: NumInLog] = req_gnt[t];
            req_wdata_o[t*ReqDataWidth +: ReqDataWidth] =
                req_wdata_i[int'(req_gnt[t])*ReqDataWidth +: ReqDataWidth];
            for (int i = 0; i < NumIn; i++) begin
                if (req_valid_o[t] && req_ready_i[t] && (req_gnt[t] == NumInLog'(i)))
                    req_ready_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        resp_valid_o = '0;
        resp_rdata_o = '0;
        resp_ready_o = '0;
        rsp_found    = '0;
        rsp_tgt_hs   = '0;
        stage_ready  = '0;
        rsp_cand     = '{default: '0};
        rsp_gnt      = '{default: '0};
        rsp_sel      = '{default: '0};
        rsp_idx      = 0;
        for (int i = 0; i < NumIn; i++) begin
            stage_ready[i] = (RespReg != 0) ? (!vld_q[i] || resp_ready_i[i]) : resp_ready_i[i];
            for (int t = 0; t < NumOut; t++) begin
                rsp_cand[i][t] = resp_valid_i[t]
                    && (resp_ini_addr_i[t*NumInLog +: NumInLog] == NumInLog'(i));
            end
            if (rsp_lock_q[i]) begin
                rsp_gnt[i]   = rsp_lidx_q[i];
                rsp_found[i] = rsp_cand[i][rsp_lidx_q[i]];
            end else begin
                for (int k = 0; k < NumOut; k++) begin
                    rsp_idx = int'(rsp_ptr_q[i]) + k;
                    if (rsp_idx >= NumOut) rsp_idx = rsp_idx - NumOut;
                    if (!rsp_found[i] && rsp_cand[i][rsp_idx]) begin
                        rsp_found[i] = 1'b1;
                        rsp_gnt[i]   = NumOutLog'(rsp_idx);
                    end
                end
            end
            rsp_sel[i]    = resp_rdata_i[int'(rsp_gnt[i])*RespDataWidth +: RespDataWidth];
            rsp_tgt_hs[i] = rsp_found[i] && stage_ready[i] && !rst_i;
            for (int t = 0; t < NumOut; t++) begin
                if (rsp_tgt_hs[i] && (rsp_gnt[i] == NumOutLog'(t)))
                    resp_ready_o[t] = 1'b1;
            end
            if (RespReg != 0) begin
                resp_valid_o[i] = vld_q[i];
                resp_rdata_o[i*RespDataWidth +: RespDataWidth] = rdata_q[i];
            end else begin
                resp_valid_o[i] = rsp_found[i] && !rst_i;
                resp_rdata_o[i*RespDataWidth +: RespDataWidth] = rsp_sel[i];
            end
        end
    end

    // Simultaneous issue and retire cancel; a retire with nothing outstanding flags a protocol error.
    always_comb begin
        err_d = err_q;
        for (int t = 0; t < NumOut; t++) begin
            req_lock_d[t] = req_valid_o[t] && !req_ready_i[t];
            req_lidx_d[t] = req_gnt[t];
            req_ptr_d[t]  = req_ptr_q[t];
            if (req_valid_o[t] && req_ready_i[t])
                req_ptr_d[t] = (int'(req_gnt[t]) == NumIn - 1) ? '0 : req_gnt[t] + 1'b1;
        end
        for (int i = 0; i < NumIn; i++) begin
            rsp_lock_d[i] = rsp_found[i] && !stage_ready[i];
            rsp_lidx_d[i] = rsp_gnt[i];
            rsp_ptr_d[i]  = rsp_ptr_q[i];
            if (rsp_tgt_hs[i])
                rsp_ptr_d[i] = (int'(rsp_gnt[i]) == NumOut - 1) ? '0 : rsp_gnt[i] + 1'b1;
            vld_d[i]   = vld_q[i];
            rdata_d[i] = rdata_q[i];
            if (RespReg != 0) begin
                if (rsp_tgt_hs[i]) begin
                    vld_d[i]   = 1'b1;
                    rdata_d[i] = rsp_sel[i];
                end else if (resp_ready_i[i]) begin
                    vld_d[i] = 1'b0;
                end
            end
            cnt_d[i] = cnt_q[i];
            if (req_ready_o[i] && !(resp_valid_o[i] && resp_ready_i[i])) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!req_ready_o[i] && resp_valid_o[i] && resp_ready_i[i]) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_lock_q <= '0;
            rsp_lock_q <= '0;
            vld_q      <= '0;
            err_q      <= 1'b0;
            for (int t = 0; t < NumOut; t++) begin
                req_lidx_q[t] <= '0;
                req_ptr_q[t]  <= '0;
            end
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i]      <= '0;
                rsp_lidx_q[i] <= '0;
                rsp_ptr_q[i]  <= '0;
                rdata_q[i]    <= '0;
            end
        end else begin
            req_lock_q <= req_lock_d;
            rsp_lock_q <= rsp_lock_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            for (int t = 0; t < NumOut; t++) begin
                req_lidx_q[t] <= req_lidx_d[t];
                req_ptr_q[t]  <= req_ptr_d[t];
            end
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i]      <= cnt_d[i];
                rsp_lidx_q[i] <= rsp_lidx_d[i];
                rsp_ptr_q[i]  <= rsp_ptr_d[i];
                rdata_q[i]    <= rdata_d[i];
            end
        end
    end

    always_comb begin
        idle_o = (vld_q == '0);
        for (int i = 0; i < NumIn; i++) begin
            outstanding_o[i*CntW +: CntW] = cnt_q[i];
            if (cnt_q[i] != '0) idle_o = 1'b0;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_credit_duplex_xbar.sv
// Bench for credit_duplex_xbar: directed corner sequences plus randomized traffic checked
// against a round-robin/credit reference model (dut0: MaxOutstanding=2, dut1: RespReg=1).
module tb_credit_duplex_xbar;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NI-1:0]   req_valid_i;
    logic [NI*2-1:0] req_tgt_addr_i;
    logic [NI*DW-1:0] req_wdata_i;
    logic [NI-1:0]   resp_ready_i;
    logic [NO-1:0]   req_ready_i;
    logic [NO-1:0]   resp_valid_i;
    logic [NO*2-1:0] resp_ini_addr_i;
    logic [NO*DW-1:0] resp_rdata_i;

    logic [NI-1:0]    d0_req_ready_o, d0_resp_valid_o, d1_req_ready_o, d1_resp_valid_o;
    logic [NI*DW-1:0] d0_resp_rdata_o, d1_resp_rdata_o;
    logic [NO-1:0]    d0_req_valid_o, d0_resp_ready_o, d1_req_valid_o, d1_resp_ready_o;
    logic [NO*2-1:0]  d0_req_ini_addr_o, d1_req_ini_addr_o;
    logic [NO*DW-1:0] d0_req_wdata_o, d1_req_wdata_o;
    logic [NI*2-1:0]  d0_outstanding_o;
    logic [NI*4-1:0]  d1_outstanding_o;
    logic             d0_idle_o, d0_err_o, d1_idle_o, d1_err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    credit_duplex_xbar #(.NumIn(NI), .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(DW),
                         .MaxOutstanding(2), .RespReg(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(d0_req_ready_o),
        .req_tgt_addr_i(req_tgt_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(d0_resp_valid_o),
        .resp_ready_i(resp_ready_i), .resp_rdata_o(d0_resp_rdata_o), .req_valid_o(d0_req_valid_o),
        .req_ready_i(req_ready_i), .req_ini_addr_o(d0_req_ini_addr_o), .req_wdata_o(d0_req_wdata_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(d0_resp_ready_o), .resp_ini_addr_i(resp_ini_addr_i),
        .resp_rdata_i(resp_rdata_i), .outstanding_o(d0_outstanding_o), .idle_o(d0_idle_o), .err_o(d0_err_o));

    credit_duplex_xbar #(.NumIn(NI), .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(DW),
                         .MaxOutstanding(8), .RespReg(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(d1_req_ready_o),
        .req_tgt_addr_i(req_tgt_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(d1_resp_valid_o),
        .resp_ready_i(resp_ready_i), .resp_rdata_o(d1_resp_rdata_o), .req_valid_o(d1_req_valid_o),
        .req_ready_i(req_ready_i), .req_ini_addr_o(d1_req_ini_addr_o), .req_wdata_o(d1_req_wdata_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(d1_resp_ready_o), .resp_ini_addr_i(resp_ini_addr_i),
        .resp_rdata_i(resp_rdata_i), .outstanding_o(d1_outstanding_o), .idle_o(d1_idle_o), .err_o(d1_err_o));

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  tgt_ready;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_ini;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    // Reference model state (dut0)
    int m_cnt[NI], m_qptr[NO], m_qlock[NO], m_sptr[NI], m_slock[NI];
    bit m_err;
    int q_own[NO], s_own[NI];
    bit req_pend[NI], resp_pend[NO];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        req_valid_i = '0; req_tgt_addr_i = '0; req_wdata_i = '0; req_ready_i = '0;
        resp_valid_i = '0; resp_ini_addr_i = '0; resp_rdata_i = '0; resp_ready_i = '0;
    endtask

    task automatic setReq(input int i, input int tgt, input logic [31:0] d);
        req_valid_i[i] = 1'b1;
        req_tgt_addr_i[i*2 +: 2] = 2'(tgt);
        req_wdata_i[i*DW +: DW] = d;
    endtask

    task automatic setResp(input int t, input int ini, input logic [31:0] d);
        resp_valid_i[t] = 1'b1;
        resp_ini_addr_i[t*2 +: 2] = 2'(ini);
        resp_rdata_i[t*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        #2;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < NI; i++)
            if (v.valid[i]) setReq(i, 2, 32'hA000_0000 + 32'(i));
        req_ready_i = v.tgt_ready;
    endtask

    function automatic bit elig(input int i, input int t);
        return req_valid_i[i] && (int'(req_tgt_addr_i[i*2 +: 2]) == t) && (m_cnt[i] < 2);
    endfunction

    function automatic bit cand(input int t, input int i);
        return resp_valid_i[t] && (int'(resp_ini_addr_i[t*2 +: 2]) == i);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0; m_qptr[k] = 0; m_qlock[k] = -1; m_sptr[k] = 0; m_slock[k] = -1;
            req_pend[k] = 0; resp_pend[k] = 0;
        end
        m_err = 0;
    endtask

    // Pick grants from model state and compare every dut0 output
    task automatic modelCheck();
        logic [3:0] e_qv, e_qr, e_sv, e_sr, a_m;
        logic [127:0] e_qd, a_qd, e_sd, a_sd;
        logic [7:0] e_qi, a_qi, e_out;
        bit e_idle;
        e_qv = '0; e_qr = '0; e_sv = '0; e_sr = '0; e_qd = '0; a_qd = '0; e_sd = '0; a_sd = '0;
        e_qi = '0; a_qi = '0; e_out = '0; e_idle = 1; a_m = '0;
        for (int t = 0; t < NO; t++) begin
            q_own[t] = -1;
            if (m_qlock[t] >= 0) begin
                if (elig(m_qlock[t], t)) q_own[t] = m_qlock[t];
            end else begin
                for (int k = 0; k < NI; k++)
                    if (q_own[t] < 0 && elig((m_qptr[t] + k) % NI, t)) q_own[t] = (m_qptr[t] + k) % NI;
            end
            if (q_own[t] >= 0) begin
                e_qv[t] = 1;
                e_qi[t*2 +: 2] = 2'(q_own[t]);
                a_qi[t*2 +: 2] = d0_req_ini_addr_o[t*2 +: 2];
                e_qd[t*DW +: DW] = req_wdata_i[q_own[t]*DW +: DW];
                a_qd[t*DW +: DW] = d0_req_wdata_o[t*DW +: DW];
                if (req_ready_i[t]) e_qr[q_own[t]] = 1;
            end
        end
        for (int i = 0; i < NI; i++) begin
            s_own[i] = -1;
            if (m_slock[i] >= 0) begin
                if (cand(m_slock[i], i)) s_own[i] = m_slock[i];
            end else begin
                for (int k = 0; k < NO; k++)
                    if (s_own[i] < 0 && cand((m_sptr[i] + k) % NO, i)) s_own[i] = (m_sptr[i] + k) % NO;
            end
            if (s_own[i] >= 0) begin
                e_sv[i] = 1;
                e_sd[i*DW +: DW] = resp_rdata_i[s_own[i]*DW +: DW];
                a_sd[i*DW +: DW] = d0_resp_rdata_o[i*DW +: DW];
                if (resp_ready_i[i]) e_sr[s_own[i]] = 1;
            end
            e_out[i*2 +: 2] = 2'(m_cnt[i]);
            if (m_cnt[i] != 0) e_idle = 0;
        end
        checkOutput("rnd req_valid_o", d0_req_valid_o, e_qv);
        checkOutput("rnd req_ready_o", d0_req_ready_o, e_qr);
        checkOutput("rnd req_ini_addr_o", a_qi, e_qi);
        checkOutput("rnd req_wdata_o", a_qd, e_qd);
        checkOutput("rnd resp_valid_o", d0_resp_valid_o, e_sv);
        checkOutput("rnd resp_rdata_o", a_sd, e_sd);
        checkOutput("rnd resp_ready_o", d0_resp_ready_o, e_sr);
        checkOutput("rnd outstanding_o", d0_outstanding_o, e_out);
        checkOutput("rnd idle_o", d0_idle_o, e_idle);
        checkOutput("rnd err_o", d0_err_o, m_err);
    endtask

    task automatic modelStep();
        bit inc[NI], dec[NI];
        for (int i = 0; i < NI; i++) begin inc[i] = 0; dec[i] = 0; end
        for (int t = 0; t < NO; t++) begin
            if (q_own[t] >= 0 && req_ready_i[t]) begin
                inc[q_own[t]] = 1; req_pend[q_own[t]] = 0;
                m_qptr[t] = (q_own[t] + 1) % NI; m_qlock[t] = -1;
            end else m_qlock[t] = q_own[t];
        end
        for (int i = 0; i < NI; i++) begin
            if (s_own[i] >= 0 && resp_ready_i[i]) begin
                dec[i] = 1; resp_pend[s_own[i]] = 0;
                m_sptr[i] = (s_own[i] + 1) % NO; m_slock[i] = -1;
            end else m_slock[i] = s_own[i];
            if (inc[i] && !dec[i]) m_cnt[i]++;
            else if (dec[i] && !inc[i]) begin
                if (m_cnt[i] == 0) m_err = 1;
                else m_cnt[i]--;
            end
        end
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        for (int n = 0; n < 5; n++) begin
            vecs[n].valid     = 4'hF;
            vecs[n].tgt_ready = 4'b0100;
            vecs[n].exp_ready = 4'(1 << (n % 4));
            vecs[n].exp_ini   = 2'(n % 4);
            vecs[n].exp_data  = 32'hA000_0000 + 32'(n % 4);
        end
        clearInputs();
        doReset();
        checkOutput("reset req_valid_o", d0_req_valid_o, 4'h0);
        checkOutput("reset idle_o", d0_idle_o, 1'b1);
        checkOutput("reset err_o", d0_err_o, 1'b0);
        checkOutput("reset outstanding_o", d0_outstanding_o, 8'h00);

        $display("[TB] contention on target 2");
        for (int n = 0; n < 5; n++) begin
            applyStimulus(vecs[n]);
            #1;
            checkOutput($sformatf("contention req_ready_o[%0d]", n), d0_req_ready_o, vecs[n].exp_ready);
            checkOutput($sformatf("contention ini_addr[%0d]", n), d0_req_ini_addr_o[4 +: 2], vecs[n].exp_ini);
            checkOutput($sformatf("contention wdata[%0d]", n), d0_req_wdata_o[64 +: 32], vecs[n].exp_data);
            step();
        end

        $display("[TB] credit limit");
        clearInputs();
        doReset();
        req_ready_i = 4'b0001;
        setReq(1, 0, 32'h11); #1;
        checkOutput("credit first ready", d0_req_ready_o, 4'b0010);
        step();
        setReq(1, 0, 32'h12); #1;
        checkOutput("credit second ready", d0_req_ready_o, 4'b0010);
        step();
        setReq(1, 0, 32'h13); #1;
        checkOutput("credit third held", d0_req_ready_o, 4'b0000);
        checkOutput("credit req_valid_o", d0_req_valid_o, 4'b0000);
        checkOutput("credit outstanding full", d0_outstanding_o[2 +: 2], 2'd2);
        setResp(3, 1, 32'hBEEF);
        resp_ready_i = 4'b0010; #1;
        checkOutput("credit resp_valid_o", d0_resp_valid_o, 4'b0010);
        checkOutput("credit resp_rdata_o", d0_resp_rdata_o[32 +: 32], 32'hBEEF);
        checkOutput("credit resp_ready_o", d0_resp_ready_o, 4'b1000);
        step();
        resp_valid_i = '0; #1;
        checkOutput("credit after resp count", d0_outstanding_o[2 +: 2], 2'd1);
        checkOutput("credit third accepted", d0_req_ready_o, 4'b0010);
        step();
        checkOutput("credit refilled", d0_outstanding_o[2 +: 2], 2'd2);

        $display("[TB] backpressure lock");
        clearInputs();
        doReset();
        req_ready_i = 4'b0001;
        setReq(0, 0, 32'hC000_0000);
        step();
        req_ready_i = 4'b0000;
        setReq(0, 0, 32'hC000_00C0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("lock ini_addr[%0d]", k), d0_req_ini_addr_o[0 +: 2], 2'd0);
            checkOutput($sformatf("lock wdata[%0d]", k), d0_req_wdata_o[0 +: 32], 32'hC000_00C0);
            checkOutput($sformatf("lock ready[%0d]", k), d0_req_ready_o, 4'b0000);
            step();
            setReq(3, 0, 32'hC000_00C3);
        end
        req_ready_i = 4'b0001; #1;
        checkOutput("lock release first", d0_req_ready_o, 4'b0001);
        step();
        req_valid_i[0] = 1'b0; #1;
        checkOutput("lock release second", d0_req_ready_o, 4'b1000);
        checkOutput("lock second ini_addr", d0_req_ini_addr_o[0 +: 2], 2'd3);
        step();

        $display("[TB] registered response path");
        clearInputs();
        doReset();
        setResp(1, 2, 32'h5151);
        setResp(3, 2, 32'h5353);
        resp_ready_i = 4'hF; #1;
        checkOutput("respreg cycle0 valid", d1_resp_valid_o, 4'b0000);
        checkOutput("respreg cycle0 tgt ready", d1_resp_ready_o, 4'b0010);
        step();
        resp_valid_i[1] = 1'b0; #1;
        checkOutput("respreg cycle1 valid", d1_resp_valid_o, 4'b0100);
        checkOutput("respreg cycle1 data", d1_resp_rdata_o[64 +: 32], 32'h5151);
        checkOutput("respreg cycle1 tgt ready", d1_resp_ready_o, 4'b1000);
        step();
        resp_valid_i[3] = 1'b0; #1;
        checkOutput("respreg cycle2 valid", d1_resp_valid_o, 4'b0100);
        checkOutput("respreg cycle2 data", d1_resp_rdata_o[64 +: 32], 32'h5353);
        step();
        checkOutput("respreg cycle3 valid", d1_resp_valid_o, 4'b0000);

        $display("[TB] protocol error");
        clearInputs();
        doReset();
        setResp(0, 3, 32'h66);
        resp_ready_i = 4'b1000; #1;
        checkOutput("err before", d0_err_o, 1'b0);
        step();
        clearInputs(); #1;
        checkOutput("err set", d0_err_o, 1'b1);
        checkOutput("err count stays 0", d0_outstanding_o, 8'h00);
        step(); step(); step();
        checkOutput("err sticky", d0_err_o, 1'b1);

        $display("[TB] reset mid-burst");
        setReq(0, 1, 32'hD0);
        setReq(2, 1, 32'hD2);
        req_ready_i = 4'hF;
        step(); step();
        checkOutput("burst outstanding", d0_outstanding_o, 8'h11);
        rst_i = 1'b1; #1;
        checkOutput("in reset req_valid_o", d0_req_valid_o, 4'h0);
        checkOutput("in reset req_ready_o", d0_req_ready_o, 4'h0);
        checkOutput("in reset resp_valid_o", d0_resp_valid_o, 4'h0);
        checkOutput("in reset idle_o", d0_idle_o, 1'b1);
        checkOutput("in reset err_o", d0_err_o, 1'b0);
        step();
        rst_i = 1'b0;
        clearInputs(); #1;
        checkOutput("after reset outstanding", d0_outstanding_o, 8'h00);
        checkOutput("after reset err_o", d0_err_o, 1'b0);

        $display("[TB] randomized traffic");
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk_i);
            for (int i = 0; i < NI; i++) begin
                if (!req_pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_pend[i] = 1;
                        setReq(i, int'($urandom_range(0, 3)), $urandom);
                    end else req_valid_i[i] = 1'b0;
                end
            end
            req_ready_i = 4'($urandom);
            for (int t = 0; t < NO; t++) begin
                if (!resp_pend[t]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        int ini;
                        ini = int'($urandom_range(0, 3));
                        if ($urandom_range(0, 99) < 97)
                            for (int k = 0; k < NI; k++)
                                if (m_cnt[(ini + k) % NI] > 0 && m_cnt[ini] == 0) ini = (ini + k) % NI;
                        resp_pend[t] = 1;
                        setResp(t, ini, $urandom);
                    end else resp_valid_i[t] = 1'b0;
                end
            end
            resp_ready_i = ($urandom_range(0, 3) != 0) ? 4'($urandom) | 4'($urandom) : 4'($urandom);
            #2;
            modelCheck();
            @(posedge clk_i);
            modelStep();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
